insight_tap_arbiter: RTL and testbench

INSIGHT_TAP_ARBITER -- requirements
Module: insight_tap_arbiter

---
 rtl/insight_tap_arbiter.sv | 148 ++++++++++++++
 tb/tb_insight_tap_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/insight_tap_arbiter.sv
// Round-robin trace-tap arbiter: one holding register per source feeding a single output register.
// Optional drop counter is built only when INSIGHT_TAP_DROP_CNT_EN is defined.
module insight_tap_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SRC_W-1:0]          out_src,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_ovf,
  output logic [15:0]               drop_cnt,
  input  logic                      drop_clr
);

  logic [NUM_SRC-1:0] hold_vld;
  logic [NUM_SRC-1:0] hold_ovf;
  logic [DATA_W-1:0]  hold_data [NUM_SRC];

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   sel_idx;
  logic               sel_found;
  logic               load;

  logic [NUM_SRC-1:0] drain;
  logic [NUM_SRC-1:0] capture;
  logic [NUM_SRC-1:0] drop;

  // Scan pending holds starting at rr_ptr, wrapping past the last source.
  always_comb begin
    int         idx;
    logic [SRC_W-1:0] idx_w;
    sel_idx   = '0;
    sel_found = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      idx_w = SRC_W'(idx);
      if (!sel_found && hold_vld[idx_w]) begin
        sel_found = 1'b1;
        sel_idx   = idx_w;
      end
    end
  end

  assign load = sel_found && (!out_valid || out_ready);

  // A hold drained this cycle can accept a new sample without recording a drop.
  always_comb begin
    drain   = '0;
    capture = '0;
    drop    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      drain[i]   = load && (sel_idx == SRC_W'(i));
      capture[i] = en && src_valid[i] && (!hold_vld[i] || drain[i]);
      drop[i]    = en && src_valid[i] && hold_vld[i] && !drain[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_vld <= '0;
      hold_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (capture[i]) begin
          hold_vld[i] <= 1'b1;
        end else if (drain[i]) begin
          hold_vld[i] <= 1'b0;
        end
        if (drop[i]) begin
          hold_ovf[i] <= 1'b1;
        end else if (drain[i]) begin
          hold_ovf[i] <= 1'b0;
        end
      end
    end
  end

  // Payload storage is qualified by hold_vld, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (capture[i]) begin
        hold_data[i] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_src   <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_src   <= sel_idx;
      out_data  <= hold_data[sel_idx];
      out_ovf   <= hold_ovf[sel_idx];
      rr_ptr    <= (sel_idx == SRC_W'(NUM_SRC - 1)) ? '0 : sel_idx + SRC_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef INSIGHT_TAP_DROP_CNT_EN
  logic [3:0]  drop_pop;
  logic [16:0] drop_sum;

  // Wide sum so that overflow past 0xFFFF can be detected and clamped.
  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_pop = drop_pop + 4'(drop[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= '0;
    end else if (drop_sum[16]) begin
      drop_cnt <= 16'hFFFF;
    end else begin
      drop_cnt <= drop_sum[15:0];
    end
  end
`else
  logic unused_drop_clr;

  assign unused_drop_clr = drop_clr;
  assign drop_cnt        = '0;
`endif

endmodule

// File: tb/tb_insight_tap_arbiter.sv
// Testbench for insight_tap_arbiter: directed vectors plus a cycle-level reference model
// of the holds, round-robin pointer and output register, compared on every falling edge.
module tb_insight_tap_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [31:0] src_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_src;
  logic [7:0]  out_data;
  logic        out_ovf;
  logic [15:0] drop_cnt;
  logic        drop_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  insight_tap_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .src_valid (src_valid),
    .src_data  (src_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .drop_cnt  (drop_cnt),
    .drop_clr  (drop_clr)
  );

  always #5 clock = ~clock;

  // Reference state: what each source is holding and what the sink currently sees.
  bit         m_hv [NUM_SRC];
  bit         m_ho [NUM_SRC];
  logic [7:0] m_hd [NUM_SRC];
  int         m_ptr = 0;
  bit         m_ov = 0;
  int         m_src = 0;
  logic [7:0] m_data = '0;
  bit         m_ovf = 0;
  int         m_cnt = 0;
  bit         started = 0;

  always @(posedge clock) begin
    int sel;
    int n_drop;
    started = 1;
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        m_hv[i] = 0;
        m_ho[i] = 0;
      end
      m_ptr = 0; m_ov = 0; m_src = 0; m_data = '0; m_ovf = 0; m_cnt = 0;
    end else begin
      sel = -1;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (sel < 0 && m_hv[(m_ptr + k) % NUM_SRC]) sel = (m_ptr + k) % NUM_SRC;
      end
      if (sel >= 0 && (!m_ov || out_ready)) begin
        m_ov = 1; m_src = sel; m_data = m_hd[sel]; m_ovf = m_ho[sel];
        m_hv[sel] = 0; m_ho[sel] = 0;
        m_ptr = (sel + 1) % NUM_SRC;
      end else if (out_ready) begin
        m_ov = 0;
      end
      n_drop = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (en && src_valid[i]) begin
          if (!m_hv[i]) begin
            m_hv[i] = 1;
            m_hd[i] = src_data[i*DATA_W +: DATA_W];
          end else begin
            m_ho[i] = 1;
            n_drop++;
          end
        end
      end
`ifdef INSIGHT_TAP_DROP_CNT_EN
      if (drop_clr) m_cnt = 0;
      else m_cnt = (m_cnt + n_drop > 65535) ? 65535 : m_cnt + n_drop;
`endif
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      check_output("model out_valid", 32'(out_valid), 32'(m_ov));
      check_output("model out_src", 32'(out_src), 32'(m_src));
      check_output("model out_data", 32'(out_data), 32'(m_data));
      check_output("model out_ovf", 32'(out_ovf), 32'(m_ovf));
      check_output("model drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    end
  end

  task automatic apply_stimulus(input logic e, input logic [3:0] v, input logic [31:0] d,
                                input logic clr);
    en = e; src_valid = v; src_data = d; drop_clr = clr;
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 4'b0000, 32'h0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, with samples offered while reset is held.
    apply_stimulus(1'b1, 4'b1111, 32'hDEADBEEF, 1'b0);
    apply_stimulus(1'b1, 4'b1111, 32'hDEADBEEF, 1'b0);
    check_output("reset out_valid", 32'(out_valid), 32'd0);
    check_output("reset out_data", 32'(out_data), 32'd0);
    check_output("reset drop_cnt", 32'(drop_cnt), 32'd0);
    reset = 1'b0;

    // Single sample, two-cycle latency.
    apply_stimulus(1'b1, 4'b0001, 32'h000000A5, 1'b0);
    idle();
    check_output("single out_valid", 32'(out_valid), 32'd1);
    check_output("single out_src", 32'(out_src), 32'd0);
    check_output("single out_data", 32'(out_data), 32'hA5);
    check_output("single out_ovf", 32'(out_ovf), 32'd0);

    // All four sources at once drain in order 0,1,2,3.
    pulse_reset();
    apply_stimulus(1'b1, 4'b1111, 32'h13121110, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle();
      check_output("rr out_src", 32'(out_src), 32'(i));
      check_output("rr out_data", 32'(out_data), 32'h10 + 32'(i));
    end
    idle();
    check_output("rr empty out_valid", 32'(out_valid), 32'd0);

    // Backpressure holds 0x20; 0x22 arrives onto a full hold and is dropped.
    pulse_reset();
    out_ready = 1'b0;
    apply_stimulus(1'b1, 4'b0010, 32'h00002000, 1'b0);
    idle();
    check_output("bp first out_data", 32'(out_data), 32'h20);
    apply_stimulus(1'b1, 4'b0010, 32'h00002100, 1'b0);
    apply_stimulus(1'b1, 4'b0010, 32'h00002200, 1'b0);
    check_output("bp stall out_valid", 32'(out_valid), 32'd1);
    check_output("bp stall out_data", 32'(out_data), 32'h20);
`ifdef INSIGHT_TAP_DROP_CNT_EN
    check_output("bp drop_cnt", 32'(drop_cnt), 32'd1);
`else
    check_output("bp drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    out_ready = 1'b1;
    idle();
    check_output("bp next out_src", 32'(out_src), 32'd1);
    check_output("bp next out_data", 32'(out_data), 32'h21);
    check_output("bp next out_ovf", 32'(out_ovf), 32'd1);
    idle();
    check_output("bp drained out_valid", 32'(out_valid), 32'd0);

    // Pointer wraps: after src2, src3 wins over src0.
    pulse_reset();
    apply_stimulus(1'b1, 4'b0100, 32'h00320000, 1'b0);
    idle();
    check_output("wrap first out_src", 32'(out_src), 32'd2);
    apply_stimulus(1'b1, 4'b1001, 32'h33000030, 1'b0);
    idle();
    check_output("wrap second out_src", 32'(out_src), 32'd3);
    check_output("wrap second out_data", 32'(out_data), 32'h33);
    idle();
    check_output("wrap third out_src", 32'(out_src), 32'd0);
    check_output("wrap third out_data", 32'(out_data), 32'h30);

    // Reset mid-stream discards the in-flight message and pending holds.
    pulse_reset();
    out_ready = 1'b0;
    apply_stimulus(1'b1, 4'b1111, 32'h43424140, 1'b0);
    idle();
    check_output("midrst before out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    apply_stimulus(1'b1, 4'b1111, 32'h53525150, 1'b0);
    check_output("midrst out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check_output("midrst after out_valid", 32'(out_valid), 32'd0);
    end

    // Counter saturation, then clear winning over a concurrent drop.
    pulse_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16400; i++) begin
      apply_stimulus(1'b1, 4'b1111, 32'h01020304, 1'b0);
    end
`ifdef INSIGHT_TAP_DROP_CNT_EN
    check_output("sat drop_cnt", 32'(drop_cnt), 32'hFFFF);
`else
    check_output("sat drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    apply_stimulus(1'b1, 4'b1111, 32'h01020304, 1'b1);
    check_output("clr drop_cnt", 32'(drop_cnt), 32'd0);
    out_ready = 1'b1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
